// File: rtl/pc_npc_ctrl_if.sv
// Fetch-control bundle between the condition handler / fetch stage and the PC/nPC pair.
// Names match the architectural signal names used throughout the front end.
interface pc_npc_ctrl_if;
    logic        LE;
    logic        J;
    logic [31:0] TA;
    logic        NUL;
    logic [31:0] PC;
    logic [31:0] nPC;
    logic        flush_if;
    logic        redirect;
    logic [15:0] taken_cnt;

    modport master (
        output LE, J, TA, NUL,
        input  PC, nPC, flush_if, redirect, taken_cnt
    );

    modport slave (
        input  LE, J, TA, NUL,
        output PC, nPC, flush_if, redirect, taken_cnt
    );
endinterface

// File: rtl/pc_npc_ctrl.sv
// PA-RISC PC/nPC pair with delayed-branch semantics. A branch resolved during a stall is
// parked in PEND until the pipeline advances; a saturating taken-branch counter aids debug.
module pc_npc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_npc_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        flush_q, flush_d;
    logic        redir_q, redir_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pend_ta_q, pend_ta_d;
    logic        pend_nul_q, pend_nul_d;

    function automatic logic [31:0] align_ta(input logic [31:0] ta);
        return ta & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + 32'd4;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            cnt_q      <= 16'd0;
            pend_ta_q  <= 32'd0;
            pend_nul_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            cnt_q      <= cnt_d;
            pend_ta_q  <= pend_ta_d;
            pend_nul_q <= pend_nul_d;
        end
    end

    // Flush/redirect default low so they pulse only on edges that apply a taken branch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        flush_d    = 1'b0;
        redir_d    = 1'b0;
        cnt_d      = cnt_q;
        pend_ta_d  = pend_ta_q;
        pend_nul_d = pend_nul_q;

        unique case (state_q)
            RUN: begin
                if (bus.LE) begin
                    pc_d = npc_q;
                    if (bus.J) begin
                        npc_d   = align_ta(bus.TA);
                        flush_d = bus.NUL;
                        redir_d = 1'b1;
                        cnt_d   = sat_inc(cnt_q);
                    end else begin
                        npc_d = npc_q + 32'd4;
                    end
                end else if (bus.J) begin
                    pend_ta_d  = align_ta(bus.TA);
                    pend_nul_d = bus.NUL;
                    state_d    = PEND;
                end
            end
            PEND: begin
                // J/TA are ignored here: the captured branch owns the next advance.
                if (bus.LE) begin
                    pc_d    = npc_q;
                    npc_d   = pend_ta_q;
                    flush_d = pend_nul_q;
                    redir_d = 1'b1;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.PC        = pc_q;
    assign bus.nPC       = npc_q;
    assign bus.flush_if  = flush_q;
    assign bus.redirect  = redir_q;
    assign bus.taken_cnt = cnt_q;

endmodule
